// File: rtl/ula_pkg.sv
// Shared types and constants for the divider result path.
// Holds the FSM state encoding and the double-dabble digit correction.
package ula_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int BCD_DIGITS  = 3;
  localparam int BCD_W       = 12;
  localparam int CONV_CYCLES = 8;

  // A digit is at most 9 here, so the +3 correction stays within 4 bits.
  function automatic logic [3:0] dd_correct(input logic [3:0] digit);
    dd_correct = (digit >= 4'd5) ? (digit + 4'd3) : digit;
  endfunction

endpackage

// File: rtl/div_result_bcd_if.sv
// Bus between the ALU control side and the BCD result converter.
// The master drives the divider results and start; the slave returns BCD results.
interface div_result_bcd_if #(parameter int WIDTH = 8);
  import ula_pkg::*;

  logic             start;
  logic [WIDTH-1:0] Quotient;
  logic [WIDTH-1:0] Remainder;
  logic             Error;
  logic             Fractional;
  logic             busy;
  logic             done;
  logic [BCD_W-1:0] q_bcd;
  logic [BCD_W-1:0] r_bcd;
  logic             err_flag;
  logic             frac_flag;

  modport master (
    output start, Quotient, Remainder, Error, Fractional,
    input  busy, done, q_bcd, r_bcd, err_flag, frac_flag
  );

  modport slave (
    input  start, Quotient, Remainder, Error, Fractional,
    output busy, done, q_bcd, r_bcd, err_flag, frac_flag
  );

endinterface

// File: rtl/bcd_dd_step.sv
// One double-dabble iteration: correct every digit >=5 by +3, then shift in one bit.
module bcd_dd_step
  import ula_pkg::*;
(
  input  logic [BCD_W-1:0] i_bcd,
  input  logic             i_bit,
  output logic [BCD_W-1:0] o_bcd
);

  logic [BCD_W-1:0] w_adj;

  // Per-digit add-3 correction ahead of the shift.
  always_comb begin
    w_adj = i_bcd;
    for (int d = 0; d < BCD_DIGITS; d++) begin
      w_adj[4*d +: 4] = dd_correct(i_bcd[4*d +: 4]);
    end
  end

  assign o_bcd = (w_adj << 1) | {{(BCD_W-1){1'b0}}, i_bit};

endmodule

// File: rtl/div_result_bcd.sv
// Captures divider quotient/remainder on start and converts both to 3-digit BCD,
// one bit per clock. An Error start skips conversion and reports zeros with err_flag.
module div_result_bcd
  import ula_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  div_result_bcd_if.slave bus
);

  state_t           r_state;
  logic [2:0]       r_cnt;
  logic [WIDTH-1:0] r_q_sh;
  logic [WIDTH-1:0] r_r_sh;
  logic [BCD_W-1:0] r_q_acc;
  logic [BCD_W-1:0] r_r_acc;
  logic [BCD_W-1:0] r_q_bcd;
  logic [BCD_W-1:0] r_r_bcd;
  logic             r_frac_lat;
  logic             r_err_lat;
  logic             r_busy;
  logic             r_done;
  logic             r_err;
  logic             r_frac;

  logic [BCD_W-1:0] w_q_next;
  logic [BCD_W-1:0] w_r_next;

  bcd_dd_step u_step_q (
    .i_bcd (r_q_acc),
    .i_bit (r_q_sh[WIDTH-1]),
    .o_bcd (w_q_next)
  );

  bcd_dd_step u_step_r (
    .i_bcd (r_r_acc),
    .i_bit (r_r_sh[WIDTH-1]),
    .o_bcd (w_r_next)
  );

  // Control FSM, operand shifters, accumulators and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_cnt      <= 3'd0;
      r_q_sh     <= {WIDTH{1'b0}};
      r_r_sh     <= {WIDTH{1'b0}};
      r_q_acc    <= {BCD_W{1'b0}};
      r_r_acc    <= {BCD_W{1'b0}};
      r_q_bcd    <= {BCD_W{1'b0}};
      r_r_bcd    <= {BCD_W{1'b0}};
      r_frac_lat <= 1'b0;
      r_err_lat  <= 1'b0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_frac     <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_done <= 1'b0;
          if (bus.start) begin
            // Error takes one pass through SHIFT so DONE lands one edge after start.
            r_state    <= SHIFT;
            r_busy     <= 1'b1;
            r_cnt      <= 3'd0;
            r_q_sh     <= bus.Quotient;
            r_r_sh     <= bus.Remainder;
            r_q_acc    <= {BCD_W{1'b0}};
            r_r_acc    <= {BCD_W{1'b0}};
            r_frac_lat <= bus.Fractional;
            r_err_lat  <= bus.Error;
          end else begin
            r_busy <= 1'b0;
          end
        end
        SHIFT: begin
          if (r_err_lat) begin
            r_state <= DONE;
            r_done  <= 1'b1;
            r_cnt   <= 3'd0;
            r_q_bcd <= {BCD_W{1'b0}};
            r_r_bcd <= {BCD_W{1'b0}};
            r_err   <= 1'b1;
            r_frac  <= 1'b0;
          end else begin
            r_q_acc <= w_q_next;
            r_r_acc <= w_r_next;
            r_q_sh  <= {r_q_sh[WIDTH-2:0], 1'b0};
            r_r_sh  <= {r_r_sh[WIDTH-2:0], 1'b0};
            r_cnt   <= r_cnt + 3'd1;
            if (r_cnt == 3'(CONV_CYCLES - 1)) begin
              r_state <= DONE;
              r_done  <= 1'b1;
              r_q_bcd <= w_q_next;
              r_r_bcd <= w_r_next;
              r_err   <= 1'b0;
              r_frac  <= r_frac_lat;
            end else begin
              r_state <= SHIFT;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.q_bcd     = r_q_bcd;
  assign bus.r_bcd     = r_r_bcd;
  assign bus.err_flag  = r_err;
  assign bus.frac_flag = r_frac;

endmodule
